// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encodings and defaults.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  localparam int MAX_LOCK_DEF = 8;
  localparam int RAM_DATA_W   = 16;

endpackage

// File: rtl/ram_arbiter_ram16k.sv
// RAM16K: single-port word RAM with combinational read and write on the clock edge.
module ram_arbiter_ram16k #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (load) mem[address] <= din;
  end

  assign dout = mem[address];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for a shared RAM16K: round-robin with bounded lock
// holds, registered grants and one-cycle read return per requester.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int MAX_LOCK = MAX_LOCK_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     addr0,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [RAM_DATA_W-1:0] wdata0,
  input  logic [RAM_DATA_W-1:0] wdata1,
  input  logic                  lock0,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [RAM_DATA_W-1:0] rdata0,
  output logic [RAM_DATA_W-1:0] rdata1
);

  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] LOCK_LIM = LCW'(MAX_LOCK - 1);

  arb_state_t            state;
  arb_state_t            nxt_state;
  logic [LCW-1:0]        lock_cnt;
  logic                  last1;
  logic                  hold0, hold1;
  logic                  xfer0_p0, xfer1_p0;
  logic                  ram_load;
  logic [ADDR_W-1:0]     ram_addr;
  logic [RAM_DATA_W-1:0] ram_wdata;
  logic [RAM_DATA_W-1:0] ram_q;

  // Stage p0: transfer cycle, granted requester drives the RAM
  always_comb begin
    xfer0_p0  = gnt0 && req0;
    xfer1_p0  = gnt1 && req1;
    ram_addr  = gnt1 ? addr1 : addr0;
    ram_wdata = gnt1 ? wdata1 : wdata0;
    ram_load  = !reset && ((xfer0_p0 && we0) || (xfer1_p0 && we1));
  end

  ram_arbiter_ram16k #(
    .ADDR_W (ADDR_W),
    .DATA_W (RAM_DATA_W)
  ) u_ram (
    .clock   (clock),
    .load    (ram_load),
    .address (ram_addr),
    .din     (ram_wdata),
    .dout    (ram_q)
  );

  // A locked owner keeps the RAM until its hold count is spent; then round-robin.
  always_comb begin
    hold0     = (state == ST_OWN0) && req0 && lock0 && (lock_cnt < LOCK_LIM);
    hold1     = (state == ST_OWN1) && req1 && lock1 && (lock_cnt < LOCK_LIM);
    nxt_state = ST_IDLE;
    if (hold0)              nxt_state = ST_OWN0;
    else if (hold1)         nxt_state = ST_OWN1;
    else if (req0 && req1)  nxt_state = last1 ? ST_OWN0 : ST_OWN1;
    else if (req0)          nxt_state = ST_OWN0;
    else if (req1)          nxt_state = ST_OWN1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      lock_cnt <= '0;
      last1    <= 1'b1;
    end else begin
      state    <= nxt_state;
      gnt0     <= (nxt_state == ST_OWN0);
      gnt1     <= (nxt_state == ST_OWN1);
      lock_cnt <= (hold0 || hold1) ? lock_cnt + LCW'(1) : '0;
      if (nxt_state == ST_OWN0)      last1 <= 1'b0;
      else if (nxt_state == ST_OWN1) last1 <= 1'b1;
    end
  end

  // Stage p1: read data returned to the requester that owned the transfer
  always_ff @(posedge clock) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= xfer0_p0 && !we0;
      rvalid1 <= xfer1_p0 && !we1;
      if (xfer0_p0 && !we0) rdata0 <= ram_q;
      if (xfer1_p0 && !we1) rdata1 <= ram_q;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, write/read, round-robin, lock, streaming, reset abort, hazard.
module tb_ram_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [13:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  ram_arbiter #(.ADDR_W(14), .MAX_LOCK(8)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0 got %b want 0", gnt0); end
    vectors++; if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL reset_gnt1 got %b want 0", gnt1); end
    vectors++; if ({rvalid0, rvalid1} !== 2'b00) begin miscompares++; $display("FAIL reset_rvalid got %b want 00", {rvalid0, rvalid1}); end
    vectors++; if (rdata0 !== 16'h0) begin miscompares++; $display("FAIL reset_rdata0 got %h want 0000", rdata0); end
    vectors++; if (rdata1 !== 16'h0) begin miscompares++; $display("FAIL reset_rdata1 got %h want 0000", rdata1); end
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 14'd5; wdata0 = 16'h1234;
    step();
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL wr_gnt0 got %b want 1", gnt0); end
    step();
    we0 = 0;
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL rd_gnt0 got %b want 1", gnt0); end
    vectors++; if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL wr_rvalid0 got %b want 0", rvalid0); end
    step();
    req0 = 0;
    vectors++; if (rvalid0 !== 1'b1) begin miscompares++; $display("FAIL rd_rvalid0 got %b want 1", rvalid0); end
    vectors++; if (rdata0 !== 16'h1234) begin miscompares++; $display("FAIL rd_rdata0 got %h want 1234", rdata0); end
    step();
    vectors++; if (rvalid0 !== 1'b0) begin miscompares++; $display("FAIL rd_rvalid0_pulse got %b want 0", rvalid0); end
    vectors++; if (gnt0 !== 1'b0) begin miscompares++; $display("FAIL rd_gnt0_release got %b want 0", gnt0); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp0;
    exp0 = 4'b0101;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 14'd1; addr1 = 14'd2;
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (gnt0 !== exp0[i]) begin miscompares++; $display("FAIL rr_gnt0[%0d] got %b want %b", i, gnt0, exp0[i]); end
      vectors++; if (gnt1 !== !exp0[i]) begin miscompares++; $display("FAIL rr_gnt1[%0d] got %b want %b", i, gnt1, !exp0[i]); end
      step();
    end
    req0 = 0; req1 = 0;
    step();
  endtask

  task automatic test_lock();
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL lock_hold[%0d] got %b want 10", i, {gnt0, gnt1}); end
      step();
    end
    vectors++; if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL lock_yield got %b want 01", {gnt0, gnt1}); end
    step();
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL lock_regain got %b want 10", {gnt0, gnt1}); end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req1 = 1; we1 = 1; addr1 = 14'd0; wdata1 = 16'hA000;
    step();
    for (int i = 0; i < 10; i++) begin
      addr1 = 14'(i); wdata1 = 16'hA000 + 16'(i);
      vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_gnt1[%0d] got %b want 1", i, gnt1); end
      step();
    end
    we1 = 0;
    for (int i = 0; i < 10; i++) begin
      addr1 = 14'(i);
      vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL b2b_rd_gnt1[%0d] got %b want 1", i, gnt1); end
      if (i == 0) begin
        vectors++; if (rvalid1 !== 1'b0) begin miscompares++; $display("FAIL b2b_rvalid1_first got %b want 0", rvalid1); end
      end else begin
        vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid1[%0d] got %b want 1", i, rvalid1); end
        vectors++; if (rdata1 !== 16'hA000 + 16'(i - 1)) begin miscompares++; $display("FAIL b2b_rdata1[%0d] got %h want %h", i, rdata1, 16'hA000 + 16'(i - 1)); end
      end
      step();
    end
    req1 = 0;
    vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid1_last got %b want 1", rvalid1); end
    vectors++; if (rdata1 !== 16'hA009) begin miscompares++; $display("FAIL b2b_rdata1_last got %h want a009", rdata1); end
    step();
    vectors++; if ({gnt1, rvalid1} !== 2'b00) begin miscompares++; $display("FAIL b2b_end got %b want 00", {gnt1, rvalid1}); end
    vectors++; if (rdata0 !== 16'h0) begin miscompares++; $display("FAIL b2b_rdata0_untouched got %h want 0000", rdata0); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    req0 = 1; we0 = 1; addr0 = 14'd7; wdata0 = 16'h7777;
    step();
    step();
    idle_inputs();
    req1 = 1; we1 = 1; addr1 = 14'd7; wdata1 = 16'hBEEF;
    step();
    vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL abort_gnt1 got %b want 1", gnt1); end
    reset = 1;
    step();
    vectors++; if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000) begin miscompares++; $display("FAIL abort_outputs got %b want 0000", {gnt0, gnt1, rvalid0, rvalid1}); end
    reset = 0;
    idle_inputs();
    req0 = 1; addr0 = 14'd7; req1 = 1; addr1 = 14'd7;
    step();
    vectors++; if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL abort_first_tie got %b want 10", {gnt0, gnt1}); end
    step();
    req0 = 0;
    vectors++; if (rvalid0 !== 1'b1) begin miscompares++; $display("FAIL abort_rvalid0 got %b want 1", rvalid0); end
    vectors++; if (rdata0 !== 16'h7777) begin miscompares++; $display("FAIL abort_ram7_via0 got %h want 7777", rdata0); end
    vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL abort_gnt1_turn got %b want 1", gnt1); end
    step();
    req1 = 0;
    vectors++; if (rvalid1 !== 1'b1) begin miscompares++; $display("FAIL abort_rvalid1 got %b want 1", rvalid1); end
    vectors++; if (rdata1 !== 16'h7777) begin miscompares++; $display("FAIL abort_ram7_via1 got %h want 7777", rdata1); end
    step();
    step();
  endtask

  task automatic test_hazard();
    req0 = 1; we0 = 1; addr0 = 14'd3; wdata0 = 16'h3333;
    step();
    step();
    we0 = 0;
    req1 = 1; we1 = 1; addr1 = 14'd3; wdata1 = 16'h4444;
    step();
    vectors++; if (rvalid0 !== 1'b1) begin miscompares++; $display("FAIL haz_rvalid0_old got %b want 1", rvalid0); end
    vectors++; if (rdata0 !== 16'h3333) begin miscompares++; $display("FAIL haz_rdata0_old got %h want 3333", rdata0); end
    vectors++; if (gnt1 !== 1'b1) begin miscompares++; $display("FAIL haz_gnt1 got %b want 1", gnt1); end
    step();
    req1 = 0; we1 = 0;
    vectors++; if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL haz_gnt0 got %b want 1", gnt0); end
    vectors++; if ({rvalid0, rdata0} !== {1'b0, 16'h3333}) begin miscompares++; $display("FAIL haz_rdata0_hold got %b/%h want 0/3333", rvalid0, rdata0); end
    step();
    req0 = 0;
    vectors++; if (rvalid0 !== 1'b1) begin miscompares++; $display("FAIL haz_rvalid0_new got %b want 1", rvalid0); end
    vectors++; if (rdata0 !== 16'h4444) begin miscompares++; $display("FAIL haz_rdata0_new got %h want 4444", rdata0); end
    vectors++; if ({rvalid1, rdata1} !== {1'b0, 16'h7777}) begin miscompares++; $display("FAIL haz_rdata1_untouched got %b/%h want 0/7777", rvalid1, rdata1); end
    step();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock();
    test_back_to_back();
    test_reset_abort();
    test_hazard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 14, word-address width of the shared RAM16K.
REQ-002 Parameter: MAX_LOCK, default 8, maximum consecutive grant cycles one locked requester holds.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0, req1  input  1 each  access request, per requester.
REQ-006 we0, we1  input  1 each  write enable (1 = write, 0 = read).
REQ-007 addr0, addr1  input  ADDR_W each  word address.
REQ-008 wdata0, wdata1  input  16 each  write data.
REQ-009 lock0, lock1  input  1 each  hold ownership for back-to-back transfers (read-modify-write).
REQ-010 gnt0, gnt1  output  1 each  registered grant, at most one high per cycle.
REQ-011 rvalid0, rvalid1  output  1 each  read data valid, one-cycle pulse.
REQ-012 rdata0, rdata1  output  16 each  registered read data.

Function
REQ-013 A transfer SHALL occur for requester X in any cycle where gntX && reqX are both high; gntX with reqX low SHALL be an idle slot with no RAM access.
REQ-014 RAM address SHALL be addrX of the granted requester; RAM load SHALL be gntX && reqX && weX; no write when neither grant is high.
REQ-015 Writes SHALL commit at the clock edge ending the transfer cycle.
REQ-016 Reads SHALL capture RAM output into rdataX at the edge ending the transfer cycle; rvalidX SHALL be high the following cycle only; read latency from transfer cycle = 1.
REQ-017 rdataX SHALL hold its last value until the next read by X; rdataY unchanged by X's reads.
REQ-018 Grant SHALL be computed at each edge from current req/lock; states IDLE (no grant), OWN0 (gnt0), OWN1 (gnt1).
REQ-019 Locked hold: if owner X has reqX && lockX high and lock_cnt < MAX_LOCK-1, next state SHALL be OWNX and lock_cnt SHALL increment.
REQ-020 Otherwise, if both requests are high, grant SHALL go to the requester not last granted (round-robin); if one request is high, to that requester; if none, IDLE.
REQ-021 lock_cnt SHALL reset to 0 whenever ownership changes or the state enters IDLE; on reaching MAX_LOCK-1 the owner SHALL lose priority for one arbitration if the other requests.
REQ-022 Single requester with req held high SHALL receive a grant every cycle (full throughput).
REQ-023 Requester SHALL keep addr/we/wdata stable while req is high and gnt is low; arbiter does not buffer requests.
REQ-024 lock is ignored when the requester is not current owner; lock with req low releases ownership.

Reset
REQ-025 On reset: state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, lock_cnt=0, last-granted=1 (requester 0 wins the first tie).
REQ-026 Reset mid-transfer or mid-lock SHALL suppress the RAM write for that cycle and drop all grants; RAM contents SHALL not be cleared.

Structure
REQ-027 State encodings (IDLE/OWN0/OWN1) and the MAX_LOCK default SHALL live in the shared definitions include.
REQ-028 The block SHALL instantiate the existing RAM16K as its single sub-module; arbitration and read-return logic in ram_arbiter.

Verification
REQ-029 Reset, then req0 write addr 5 data 0x1234, next req0 read addr 5 -> gnt0 the cycle after each req, rvalid0 one cycle after read transfer, rdata0=0x1234.
REQ-030 req0 and req1 raised together after reset, held 4 cycles -> grants alternate gnt0,gnt1,gnt0,gnt1; never both high.
REQ-031 req0+lock0 held, req1 held, MAX_LOCK=8 -> gnt0 for 8 consecutive cycles, then gnt1 for 1 cycle, then gnt0 again.
REQ-032 req1 alone held 10 cycles reading addr 0..9 -> gnt1 high 10 consecutive cycles, rvalid1 10 consecutive cycles delayed by 1.
REQ-033 Reset asserted during gnt1 with we1=1 addr 7 data 0xBEEF -> RAM[7] unchanged, gnt0/gnt1/rvalid low next cycle, first tie after reset goes to requester 0.
REQ-034 Read by requester 0 of addr 3 while requester 1 writes addr 3 in the next slot -> rdata0 returns old value, subsequent read returns new value; rdata1 unaffected.
